// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the decode/execute boundary: control bundle layout,
// hazard-responder state encoding and the ID/EX bubble constant.
package riscv_pipe_pkg;

    localparam int CTRL_W       = 8;
    localparam int REG_IDX_W    = 5;

    // Bundle layout: {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
    localparam int REGWRITE_BIT = 7;
    localparam int MEMREAD_BIT  = 6;
    localparam int MEMWRITE_BIT = 5;
    localparam int MEMTOREG_BIT = 4;
    localparam int BRANCH_BIT   = 3;
    localparam int ALUSRC_BIT   = 2;
    localparam int ALUOP_LSB    = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic [CTRL_W-1:0]    ctrl;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module hazard_perf_cnt
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_response.sv
// Load-use stall / branch flush responder owning the ID/EX register.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module pipeline_hazard_response
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              branch_taken,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic              ex_mem_read,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
`endif
    output logic [1:0]        state
);

    hazard_state_e state_q;
    hazard_state_e state_d;
    idex_t         idex_q;
    idex_t         idex_d;
    logic          stallEff;

    // A load into x0 never creates a dependency, and a flushed ID slot is a NOP.
    assign stallEff = stall_in && (idex_q.rd != 5'd0) && (state_q != ST_FLUSH);

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        state_d    = ST_RUN;
        idex_d     = '{ctrl: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_d     = IDEX_BUBBLE;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            state_d    = ST_FLUSH;
            idex_d     = IDEX_BUBBLE;
        end else if (stallEff) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = ST_BUBBLE;
            idex_d     = IDEX_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            idex_q  <= IDEX_BUBBLE;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign ex_ctrl     = idex_q.ctrl;
    assign ex_rd       = idex_q.rd;
    assign ex_rs1      = idex_q.rs1;
    assign ex_rs2      = idex_q.rs2;
    assign ex_mem_read = idex_q.ctrl[MEMREAD_BIT];
    assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stallHonored;
    logic flushHonored;

    // A stall that collides with a taken branch is dropped and not counted.
    assign stallHonored = !reset && !branch_taken && stallEff;
    assign flushHonored = !reset && branch_taken;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (stallHonored),
        .count_o (stall_count)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (flushHonored),
        .count_o (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_response.sv
// Directed self-checking bench for pipeline_hazard_response.
// Counter checks are compiled in only when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_response;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             stall_in;
    logic             branch_taken;
    logic [7:0]       id_ctrl;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic [7:0]       ex_ctrl;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic             ex_mem_read;
    logic [1:0]       state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
`endif

    int errors = 0;
    int checks = 0;
    int expStall = 0;
    int expFlush = 0;

    pipeline_hazard_response #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .branch_taken (branch_taken),
        .id_ctrl      (id_ctrl),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .ex_ctrl      (ex_ctrl),
        .ex_rd        (ex_rd),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_mem_read  (ex_mem_read),
`ifdef HAZARD_PERF_CNT_EN
        .stall_count  (stall_count),
        .flush_count  (flush_count),
`endif
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic [7:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        id_ctrl = c;
        id_rd   = rd;
        id_rs1  = rs1;
        id_rs2  = rs2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall_in = 1'b0;
        branch_taken = 1'b0;
        setId(8'hFF, 5'd31, 5'd30, 5'd29);
        tick();
        tick();
        checks++; if (ex_ctrl !== 8'h00) begin errors++; $display("[TB] FAIL reset_ex_ctrl got=%0h exp=0", ex_ctrl); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_ex_rd got=%0d exp=0", ex_rd); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_write got=%0b exp=0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_ifid_write got=%0b exp=0", ifid_write); end
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL reset_ifid_flush got=%0b exp=1", ifid_flush); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_stall_count got=%0d exp=0", stall_count); end
        checks++; if (flush_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_flush_count got=%0d exp=0", flush_count); end
`endif
        expStall = 0;
        expFlush = 0;
        reset = 1'b0;
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL release_pc_write got=%0b exp=1", pc_write); end
        checks++; if (ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL release_ifid_flush got=%0b exp=0", ifid_flush); end
    endtask

    task automatic test_load_use();
        setId(8'hD0, 5'd5, 5'd1, 5'd2);
        tick();
        checks++; if (ex_ctrl !== 8'hD0) begin errors++; $display("[TB] FAIL lu_load_ctrl got=%0h exp=d0", ex_ctrl); end
        checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("[TB] FAIL lu_mem_read got=%0b exp=1", ex_mem_read); end
        checks++; if (ex_rd !== 5'd5) begin errors++; $display("[TB] FAIL lu_load_rd got=%0d exp=5", ex_rd); end
        setId(8'h84, 5'd7, 5'd5, 5'd3);
        stall_in = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_pc_write got=%0b exp=0", pc_write); end
        checks++; if (ifid_write !== 1'b0) begin errors++; $display("[TB] FAIL lu_ifid_write got=%0b exp=0", ifid_write); end
        checks++; if (ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL lu_ifid_flush got=%0b exp=0", ifid_flush); end
        tick();
        expStall++;
        checks++; if (ex_ctrl !== 8'h00) begin errors++; $display("[TB] FAIL lu_bubble_ctrl got=%0h exp=0", ex_ctrl); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL lu_bubble_rd got=%0d exp=0", ex_rd); end
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL lu_state got=%0d exp=1", state); end
        checks++; if (ex_mem_read !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_mem_read got=%0b exp=0", ex_mem_read); end
        stall_in = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL lu_resume_pc_write got=%0b exp=1", pc_write); end
        tick();
        checks++; if (ex_rd !== 5'd7) begin errors++; $display("[TB] FAIL lu_dep_rd got=%0d exp=7", ex_rd); end
        checks++; if (ex_ctrl !== 8'h84) begin errors++; $display("[TB] FAIL lu_dep_ctrl got=%0h exp=84", ex_ctrl); end
        checks++; if (ex_rs1 !== 5'd5) begin errors++; $display("[TB] FAIL lu_dep_rs1 got=%0d exp=5", ex_rs1); end
        checks++; if (ex_rs2 !== 5'd3) begin errors++; $display("[TB] FAIL lu_dep_rs2 got=%0d exp=3", ex_rs2); end
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL lu_back_to_run got=%0d exp=0", state); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_count !== CNT_W'(expStall)) begin errors++; $display("[TB] FAIL lu_stall_count got=%0d exp=%0d", stall_count, expStall); end
`endif
    endtask

    task automatic test_x0_load();
        setId(8'h50, 5'd0, 5'd4, 5'd0);
        tick();
        checks++; if (ex_mem_read !== 1'b1) begin errors++; $display("[TB] FAIL x0_mem_read got=%0b exp=1", ex_mem_read); end
        setId(8'h80, 5'd9, 5'd0, 5'd6);
        stall_in = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL x0_pc_write got=%0b exp=1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin errors++; $display("[TB] FAIL x0_ifid_write got=%0b exp=1", ifid_write); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL x0_state got=%0d exp=0", state); end
        checks++; if (ex_rd !== 5'd9) begin errors++; $display("[TB] FAIL x0_no_bubble_rd got=%0d exp=9", ex_rd); end
        stall_in = 1'b0;
    endtask

    task automatic test_branch();
        setId(8'h82, 5'd12, 5'd1, 5'd1);
        branch_taken = 1'b1;
        #1;
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL br_ifid_flush got=%0b exp=1", ifid_flush); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL br_pc_write got=%0b exp=1", pc_write); end
        checks++; if (ifid_write !== 1'b1) begin errors++; $display("[TB] FAIL br_ifid_write got=%0b exp=1", ifid_write); end
        tick();
        expFlush++;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL br_state got=%0d exp=2", state); end
        checks++; if (ex_ctrl !== 8'h00) begin errors++; $display("[TB] FAIL br_bubble_ctrl got=%0h exp=0", ex_ctrl); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL br_bubble_rd got=%0d exp=0", ex_rd); end
        branch_taken = 1'b0;
        stall_in = 1'b1;
        setId(8'h80, 5'd13, 5'd2, 5'd2);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL br_flush_stall_pc got=%0b exp=1", pc_write); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL br_flush_exit got=%0d exp=0", state); end
        checks++; if (ex_rd !== 5'd13) begin errors++; $display("[TB] FAIL br_after_rd got=%0d exp=13", ex_rd); end
        stall_in = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (flush_count !== CNT_W'(expFlush)) begin errors++; $display("[TB] FAIL br_flush_count got=%0d exp=%0d", flush_count, expFlush); end
        checks++; if (stall_count !== CNT_W'(expStall)) begin errors++; $display("[TB] FAIL br_stall_count got=%0d exp=%0d", stall_count, expStall); end
`endif
    endtask

    task automatic test_collision();
        setId(8'hD0, 5'd3, 5'd1, 5'd2);
        tick();
        setId(8'h84, 5'd8, 5'd3, 5'd3);
        stall_in = 1'b1;
        branch_taken = 1'b1;
        #1;
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL col_ifid_flush got=%0b exp=1", ifid_flush); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL col_pc_write got=%0b exp=1", pc_write); end
        tick();
        expFlush++;
        checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL col_state got=%0d exp=2", state); end
        checks++; if (ex_ctrl !== 8'h00) begin errors++; $display("[TB] FAIL col_ctrl got=%0h exp=0", ex_ctrl); end
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (flush_count !== CNT_W'(expFlush)) begin errors++; $display("[TB] FAIL col_flush_count got=%0d exp=%0d", flush_count, expFlush); end
        checks++; if (stall_count !== CNT_W'(expStall)) begin errors++; $display("[TB] FAIL col_stall_count got=%0d exp=%0d", stall_count, expStall); end
`endif
        stall_in = 1'b0;
        branch_taken = 1'b0;
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_reset_mid_stall();
        setId(8'hD0, 5'd4, 5'd1, 5'd1);
        tick();
        setId(8'h84, 5'd6, 5'd4, 5'd4);
        stall_in = 1'b1;
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL rms_state_bubble got=%0d exp=1", state); end
        reset = 1'b1;
        #1;
        checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL rms_ifid_flush got=%0b exp=1", ifid_flush); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rms_state got=%0d exp=0", state); end
        checks++; if (ex_ctrl !== 8'h00 || ex_rd !== 5'd0) begin errors++; $display("[TB] FAIL rms_idex got=%0h/%0d exp=0/0", ex_ctrl, ex_rd); end
        expStall = 0;
        expFlush = 0;
`ifdef HAZARD_PERF_CNT_EN
        checks++; if (stall_count !== 4'd0) begin errors++; $display("[TB] FAIL rms_stall_count got=%0d exp=0", stall_count); end
`endif
        reset = 1'b0;
        stall_in = 1'b0;
        setId(8'h00, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            setId(8'hD0, 5'd10, 5'd1, 5'd1);
            stall_in = 1'b0;
            tick();
            setId(8'h84, 5'd11, 5'd10, 5'd10);
            stall_in = 1'b1;
            tick();
            expStall++;
        end
        stall_in = 1'b0;
        checks++; if (stall_count !== 4'hF) begin errors++; $display("[TB] FAIL sat_stall_count got=%0h exp=f (after %0d stalls)", stall_count, expStall); end
        checks++; if (flush_count !== 4'h0) begin errors++; $display("[TB] FAIL sat_flush_count got=%0h exp=0", flush_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_x0_load();
        test_branch();
        test_collision();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_response.md
# pipeline_hazard_response

Responder side of the load-use hazard interface: consumes the stall request from the hazard detection stage and the taken-branch flush from EX, and applies them to the pipeline. Drives PC/IF-ID write enables and the IF/ID flush, owns the ID/EX control/register-index pipeline register, and inserts bubbles. It feeds `ex_mem_read`/`ex_rd` back to the hazard detector as its previous-instruction inputs. Sits between decode and execute in the 5-stage core.

## Interface
- CTRL_W, 8, width of decoded control bundle {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
- MEMREAD_BIT, 6, bit index of MemRead inside the bundle
- CNT_W, 32, width of performance counters (macro-gated)

- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- stall_in  in  1  load-use stall request from hazard detector (combinational, same cycle)
- branch_taken  in  1  taken branch/jump resolved in EX this cycle
- id_ctrl  in  CTRL_W  decoded control bundle of instruction in ID
- id_rd, id_rs1, id_rs2  in  5 each  register indices of instruction in ID
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID clear to NOP
- ex_ctrl  out  CTRL_W  registered control bundle for EX
- ex_rd, ex_rs1, ex_rs2  out  5 each  registered indices for EX/forwarding
- ex_mem_read  out  1  ex_ctrl[MEMREAD_BIT], to hazard detector P_MemRead
- state  out  2  debug: current FSM state
- stall_count, flush_count  out  CNT_W each  present only with macro

## Operation
- States: RUN=0, BUBBLE=1 (EX holds an injected stall bubble), FLUSH=2 (EX holds a flush bubble).
- stall_eff = stall_in & (ex_rd != 0) & (state != FLUSH); loads to x0 never stall; in FLUSH the ID instruction is a cleared NOP.
- Priority: branch_taken > stall_eff > normal.
- branch_taken: pc_write=1, ifid_write=1, ifid_flush=1; next ID/EX = bubble; next state FLUSH.
- stall_eff (no branch): pc_write=0, ifid_write=0, ifid_flush=0; next ID/EX = bubble; next state BUBBLE.
- Normal: pc_write=1, ifid_write=1, ifid_flush=0; ID/EX <= {id_ctrl, id_rd, id_rs1, id_rs2}; next state RUN.
- Bubble = ex_ctrl 0, ex_rd/ex_rs1/ex_rs2 0.
- Transitions evaluated identically from every state; repeated stall_eff in BUBBLE stalls again (not expected since ex_mem_read=0).
- Reset: state RUN, ex_* all 0, counters 0; while reset high pc_write=0, ifid_write=0, ifid_flush=1.

## Timing
- pc_write, ifid_write, ifid_flush: combinational from stall_in, branch_taken, state, ex_rd, reset; zero-latency.
- ex_*, state, counters: update at rising clk edge, one-cycle latency.
- Load-use: exactly one bubble per load-use pair; cycle after, hazard detector sees ex_mem_read=0.
- Simultaneous stall_in and branch_taken: flush wins, stall dropped, stall_count unchanged.
- Reset mid-stall/flush: next edge returns to RUN with cleared ID/EX; no partial bubble survives.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_count increments on each cycle stall_eff is honored; flush_count on each branch_taken cycle; both saturate at all-ones, clear on reset.
- Undefined: counter ports and logic absent; all other behaviour identical.

## Structure
- Shared package riscv_pipe_pkg: CTRL_W, MEMREAD_BIT and other bundle bit indices, state encoding constants, bubble constant.
- One sub-module natural: hazard_perf_cnt (saturating CNT_W counter with enable), instantiated twice under the macro.
- FSM and ID/EX register in the top module.

## Test plan
- Reset: assert reset 2 cycles with id_ctrl=8'hFF -> ex_ctrl=0, ex_rd=0, state=0, pc_write=0, ifid_flush=1; release -> pc_write=1.
- Load-use: ex_ctrl MemRead=1, ex_rd=5, stall_in=1 -> pc_write=0, ifid_write=0; next edge ex_ctrl=0, state=1; following cycle ID instruction (rd=7) enters EX, ex_rd=7.
- x0 load: ex_rd=0, ex_mem_read=1, stall_in=1 -> pc_write=1, no bubble, state stays 0.
- Branch flush: branch_taken=1 -> ifid_flush=1, pc_write=1; next edge ex_ctrl=0, state=2; stall_in=1 in FLUSH ignored.
- Collision: stall_in=1, branch_taken=1, ex_rd=3 -> ifid_flush=1, state->2; with macro, flush_count+1, stall_count unchanged.
- Counter saturation (macro, CNT_W=4): 20 consecutive honored stalls -> stall_count holds 4'hF.
